// File: rtl/pilot_sched.sv
// rtl/pilot_sched.sv - OFDM pilot/data carrier allocation scheduler with per-frame pilot polarity LFSR
//
// Purpose:
//   Holds a 4096-bit base carrier map (2048 carriers x 2-bit code) written
//   through a simple word-wide config port while idle. During a frame it
//   presents the map as ALLOC_VEC. Pilot entries have their sign flipped by
//   the current polarity bit of a x^7+x^4+1 LFSR. Carriers beyond the active
//   standard's carrier count are masked to null. Each VEC_LD from the pilot
//   inserter consumes one symbol vector and steps the LFSR.
//
// Ports:
//   CLK_I      in   1     clock, all state on rising edge
//   RST_I      in   1     asynchronous active-high reset
//   CFG_DAT_I  in   32    map write data
//   CFG_ADR_I  in   7     map word index
//   CFG_STB_I  in   1     map write strobe
//   CFG_WE_I   in   1     map write enable
//   CFG_ACK_O  out  1     registered one-cycle write acknowledge
//   STD        in   2     00=64, 01=256, 10=2048 carriers, 11=disabled
//   SYM_NUM    in   8     symbols per frame, sampled at frame start
//   FRM_START  in   1     frame start request
//   VEC_LD     in   1     current vector consumed
//   ALLOC_VEC  out  4096  per-carrier code, carrier 0 in [1:0]
//   BUSY       out  1     frame in progress
//   FRM_DONE   out  1     one-cycle end-of-frame pulse

module pilot_sched #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [31:0]   CFG_DAT_I,
    input  logic [6:0]    CFG_ADR_I,
    input  logic          CFG_STB_I,
    input  logic          CFG_WE_I,
    output logic          CFG_ACK_O,
    input  logic [1:0]    STD,
    input  logic [7:0]    SYM_NUM,
    input  logic          FRM_START,
    input  logic          VEC_LD,
    output logic [4095:0] ALLOC_VEC,
    output logic          BUSY,
    output logic          FRM_DONE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [1:0] STD_OFF  = 2'b11;

    logic [1:0]    state;
    logic [6:0]    lfsr;
    logic [7:0]    sym_cnt;
    logic [7:0]    sym_num_q;
    logic [4095:0] base_map;

    logic          in_idle;
    logic          in_frame;
    logic          wr_acc;
    logic          start_ok;
    logic          pol;
    logic [7:0]    sym_cnt_nxt;
    logic          last_sym;
    logic          active;
    logic [11:0]   n_car;

    assign in_idle     = (state == ST_IDLE);
    assign in_frame    = (state == ST_ARMED) || (state == ST_RUN);

    // Map writes are only taken while idle so the vector never changes
    // under the inserter mid-frame; outside idle the request simply stalls.
    assign wr_acc      = in_idle && CFG_STB_I && CFG_WE_I;

    assign start_ok    = FRM_START && (STD != STD_OFF) && (SYM_NUM != 8'd0);

    // Polarity for the symbol currently presented, taken from the present
    // state so ALLOC_VEC is stable in the cycle VEC_LD samples it.
    assign pol         = lfsr[6] ^ lfsr[3];

    assign sym_cnt_nxt = sym_cnt + 8'd1;
    assign last_sym    = (sym_cnt_nxt == sym_num_q);

    assign BUSY        = in_frame;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= ST_IDLE;
            lfsr      <= SEED;
            sym_cnt   <= 8'd0;
            sym_num_q <= 8'd0;
            CFG_ACK_O <= 1'b0;
            FRM_DONE  <= 1'b0;
            base_map  <= '0;
        end else begin
            CFG_ACK_O <= 1'b0;
            FRM_DONE  <= 1'b0;

            if (wr_acc) begin
                base_map[{CFG_ADR_I, 5'b00000} +: 32] <= CFG_DAT_I;
                CFG_ACK_O <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_ARMED;
                        lfsr      <= SEED;
                        sym_cnt   <= 8'd0;
                        sym_num_q <= SYM_NUM;
                    end
                end

                ST_ARMED, ST_RUN: begin
                    if (VEC_LD) begin
                        lfsr    <= {lfsr[5:0], pol};
                        sym_cnt <= sym_cnt_nxt;
                        if (last_sym) begin
                            state    <= ST_IDLE;
                            FRM_DONE <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Carrier count of the selected standard; the disabled code yields zero
    // so every carrier is masked.
    always_comb begin
        n_car = 12'd0;
        case (STD)
            2'b00:   n_car = 12'd64;
            2'b01:   n_car = 12'd256;
            2'b10:   n_car = 12'd2048;
            default: n_car = 12'd0;
        endcase
    end

    assign active = in_frame && (STD != STD_OFF);

    // Pilot codes have bit 0 set (01 = +pilot, 11 = -pilot), so flipping the
    // high bit by pol only where bit 0 is set swaps pilot sign and leaves
    // null (00) and data (10) untouched.
    for (genvar i = 0; i < 2048; i++) begin : g_car
        localparam logic [11:0] CIDX = 12'(i);
        logic car_en;
        assign car_en = active && (CIDX < n_car);
        assign ALLOC_VEC[2*i+1:2*i] = car_en
            ? {base_map[2*i+1] ^ (base_map[2*i] & pol), base_map[2*i]}
            : 2'b00;
    end

endmodule

// File: tb/tb_pilot_sched.sv
// tb/tb_pilot_sched.sv - self-checking bench for pilot_sched

module tb_pilot_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg_dat;
    logic [6:0]    cfg_adr;
    logic          cfg_stb;
    logic          cfg_we;
    logic          cfg_ack;
    logic [1:0]    std_sel;
    logic [7:0]    sym_num;
    logic          frm_start;
    logic          vec_ld;
    logic [4095:0] alloc_vec;
    logic          busy;
    logic          frm_done;

    always #5 clk = ~clk;

    pilot_sched dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .CFG_DAT_I (cfg_dat),
        .CFG_ADR_I (cfg_adr),
        .CFG_STB_I (cfg_stb),
        .CFG_WE_I  (cfg_we),
        .CFG_ACK_O (cfg_ack),
        .STD       (std_sel),
        .SYM_NUM   (sym_num),
        .FRM_START (frm_start),
        .VEC_LD    (vec_ld),
        .ALLOC_VEC (alloc_vec),
        .BUSY      (busy),
        .FRM_DONE  (frm_done)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [1:0]  std;
        logic [6:0]  chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic expect_v(input string n, input logic [31:0] v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic check_v(input logic [31:0] act);
        logic [31:0] e;
        string       n;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %h with no expectation", act);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    endtask

    function automatic logic [31:0] word_of(input logic [6:0] w);
        return alloc_vec[{w, 5'b00000} +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] adr, input logic [31:0] dat);
        cfg_adr = adr;
        cfg_dat = dat;
        cfg_stb = 1'b1;
        cfg_we  = 1'b1;
        expect_v("ack_before_edge", 32'd0);
        check_v({31'd0, cfg_ack});
        tick();
        expect_v("ack_one_cycle_later", 32'd1);
        check_v({31'd0, cfg_ack});
        cfg_stb = 1'b0;
        cfg_we  = 1'b0;
        tick();
        expect_v("ack_single_pulse", 32'd0);
        check_v({31'd0, cfg_ack});
    endtask

    task automatic start_frame(input logic [1:0] s, input logic [7:0] n);
        std_sel   = s;
        sym_num   = n;
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
    endtask

    task automatic end_single_frame();
        vec_ld = 1'b1;
        tick();
        vec_ld = 1'b0;
        expect_v("frm_done_pulse", 32'd1);
        check_v({31'd0, frm_done});
        expect_v("busy_after_last", 32'd0);
        check_v({31'd0, busy});
        tick();
        expect_v("frm_done_clears", 32'd0);
        check_v({31'd0, frm_done});
    endtask

    logic [1:0] c1;
    logic [1:0] seq8 [8];

    initial begin
        rst       = 1'b1;
        cfg_dat   = '0;
        cfg_adr   = '0;
        cfg_stb   = 1'b0;
        cfg_we    = 1'b0;
        std_sel   = 2'b00;
        sym_num   = 8'd0;
        frm_start = 1'b0;
        vec_ld    = 1'b0;

        seq8[0] = 2'b01; seq8[1] = 2'b01; seq8[2] = 2'b01; seq8[3] = 2'b01;
        seq8[4] = 2'b11; seq8[5] = 2'b11; seq8[6] = 2'b11; seq8[7] = 2'b01;

        tbl[0] = '{7'd0,   32'h0000_0061, 2'b00, 7'd0,   32'h0000_0061};
        tbl[1] = '{7'd4,   32'hDEAD_BEEF, 2'b00, 7'd4,   32'h0000_0000};
        tbl[2] = '{7'd4,   32'hDEAD_BEEF, 2'b01, 7'd4,   32'hDEAD_BEEF};
        tbl[3] = '{7'd16,  32'h1234_5678, 2'b01, 7'd16,  32'h0000_0000};
        tbl[4] = '{7'd16,  32'h1234_5678, 2'b10, 7'd16,  32'h1234_5678};
        tbl[5] = '{7'd127, 32'hFFFF_FFFF, 2'b10, 7'd127, 32'hFFFF_FFFF};
        tbl[6] = '{7'd3,   32'h5555_5555, 2'b00, 7'd3,   32'h5555_5555};

        tick();
        tick();
        expect_v("rst_busy", 32'd0);     check_v({31'd0, busy});
        expect_v("rst_ack", 32'd0);      check_v({31'd0, cfg_ack});
        expect_v("rst_done", 32'd0);     check_v({31'd0, frm_done});
        expect_v("rst_alloc_any", 32'd0); check_v({31'd0, |alloc_vec});
        rst = 1'b0;
        tick();

        // Table: write, open a one-symbol frame, read the affected word.
        for (int r = 0; r < 7; r++) begin
            do_write(tbl[r].adr, tbl[r].dat);
            start_frame(tbl[r].std, 8'd1);
            expect_v("tbl_busy", 32'd1);
            check_v({31'd0, busy});
            expect_v($sformatf("tbl_word_row%0d", r), tbl[r].exp);
            check_v(word_of(tbl[r].chk));
            end_single_frame();
        end

        // Polarity sequence over 8 symbols; carrier 0 is -pilot, carrier 1
        // +pilot. A FRM_START mid-frame must not restart the LFSR.
        do_write(7'd0, 32'h0000_0007);
        start_frame(2'b00, 8'd8);
        for (int k = 0; k < 8; k++) begin
            c1 = seq8[k];
            expect_v($sformatf("pol_word0_sym%0d", k), {28'd0, c1, c1 ^ 2'b10});
            check_v(word_of(7'd0));
            vec_ld    = 1'b1;
            frm_start = (k == 4);
            tick();
            vec_ld    = 1'b0;
            frm_start = 1'b0;
            expect_v($sformatf("pol_done_sym%0d", k), (k == 7) ? 32'd1 : 32'd0);
            check_v({31'd0, frm_done});
            expect_v($sformatf("pol_busy_sym%0d", k), (k == 7) ? 32'd0 : 32'd1);
            check_v({31'd0, busy});
        end
        tick();
        expect_v("pol_done_once", 32'd0);
        check_v({31'd0, frm_done});

        // Write stalled while busy, completes once idle.
        start_frame(2'b00, 8'd2);
        cfg_adr = 7'd1;
        cfg_dat = 32'hAAAA_AAAA;
        cfg_stb = 1'b1;
        cfg_we  = 1'b1;
        tick();
        expect_v("stall_no_ack", 32'd0);   check_v({31'd0, cfg_ack});
        expect_v("stall_map_kept", 32'd0); check_v(word_of(7'd1));
        vec_ld = 1'b1;
        tick();
        expect_v("stall_no_ack_run", 32'd0); check_v({31'd0, cfg_ack});
        tick();
        vec_ld = 1'b0;
        expect_v("stall_no_ack_end", 32'd0); check_v({31'd0, cfg_ack});
        expect_v("stall_frm_done", 32'd1);   check_v({31'd0, frm_done});
        tick();
        expect_v("stall_ack_in_idle", 32'd1); check_v({31'd0, cfg_ack});
        cfg_stb = 1'b0;
        cfg_we  = 1'b0;
        tick();
        expect_v("stall_ack_clears", 32'd0); check_v({31'd0, cfg_ack});
        start_frame(2'b00, 8'd1);
        expect_v("stall_write_landed", 32'hAAAA_AAAA);
        check_v(word_of(7'd1));
        end_single_frame();

        // Reset in RUN after three symbols.
        do_write(7'd0, 32'h0000_0004);
        start_frame(2'b00, 8'd8);
        vec_ld = 1'b1;
        tick(); tick(); tick();
        vec_ld = 1'b0;
        expect_v("run_busy_pre_rst", 32'd1); check_v({31'd0, busy});
        rst = 1'b1;
        #1;
        expect_v("midrst_busy", 32'd0);  check_v({31'd0, busy});
        expect_v("midrst_alloc", 32'd0); check_v({31'd0, |alloc_vec});
        expect_v("midrst_done", 32'd0);  check_v({31'd0, frm_done});
        tick();
        rst = 1'b0;
        tick();
        start_frame(2'b10, 8'd1);
        expect_v("rst_map_cleared", 32'd0); check_v({31'd0, |alloc_vec});
        end_single_frame();
        do_write(7'd0, 32'h0000_0004);
        start_frame(2'b00, 8'd5);
        for (int k = 0; k < 5; k++) begin
            c1 = seq8[k];
            expect_v($sformatf("reseed_sym%0d", k), {28'd0, c1, 2'b00});
            check_v(word_of(7'd0));
            vec_ld = 1'b1;
            tick();
            vec_ld = 1'b0;
        end
        expect_v("reseed_done", 32'd1); check_v({31'd0, frm_done});

        // Rejected frame starts and VEC_LD in idle.
        tick();
        start_frame(2'b00, 8'd0);
        expect_v("zero_sym_idle", 32'd0); check_v({31'd0, busy});
        start_frame(2'b11, 8'd4);
        expect_v("std_off_idle", 32'd0);  check_v({31'd0, busy});
        expect_v("std_off_alloc", 32'd0); check_v({31'd0, |alloc_vec});
        vec_ld = 1'b1;
        tick();
        vec_ld = 1'b0;
        expect_v("idle_vec_ld_no_done", 32'd0); check_v({31'd0, frm_done});
        tick();
        expect_v("idle_still_no_done", 32'd0);  check_v({31'd0, frm_done});
        expect_v("idle_still_not_busy", 32'd0); check_v({31'd0, busy});

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pilot_sched.md
PILOT_SCHED -- requirements
Module: pilot_sched

Interface
REQ-001 SHALL have parameter SEED, default 7'h7F, initial pilot-polarity LFSR state loaded at every frame start.
REQ-002 SHALL have port CLK_I input 1: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_I input 1: asynchronous, active-high reset.
REQ-004 SHALL have port CFG_DAT_I input 32: map write data.
REQ-005 SHALL have port CFG_ADR_I input 7: map word index 0..127.
REQ-006 SHALL have ports CFG_STB_I, CFG_WE_I input 1 each: map write request.
REQ-007 SHALL have port CFG_ACK_O output 1: map write accepted.
REQ-008 SHALL have port STD input 2: 00 = 64 carriers, 01 = 256, 10 = 2048, 11 = disabled.
REQ-009 SHALL have port SYM_NUM input 8: symbols per frame, sampled on frame start.
REQ-010 SHALL have port FRM_START input 1: single-cycle frame start request.
REQ-011 SHALL have port VEC_LD input 1: vector-consumed strobe from the pilot inserter.
REQ-012 SHALL have port ALLOC_VEC output 4096: per-carrier 2-bit code (00 null, 10 data, 01 +pilot, 11 -pilot), carrier 0 in bits [1:0].
REQ-013 SHALL have ports BUSY and FRM_DONE output 1 each: frame in progress; one-cycle end-of-frame pulse.

Function
REQ-014 SHALL hold a 4096-bit base map; an accepted write stores CFG_DAT_I into map bits [32*ADR+31 : 32*ADR].
REQ-015 SHALL accept a write (CFG_STB_I & CFG_WE_I) only in IDLE, pulsing registered CFG_ACK_O for one cycle one clock later; outside IDLE the request is stalled with no ACK and no map change.
REQ-016 SHALL implement states IDLE, ARMED and RUN.
REQ-017 SHALL move IDLE->ARMED on FRM_START with STD != 11 and SYM_NUM != 0, loading LFSR = SEED, sym_cnt = 0 and latching SYM_NUM; otherwise FRM_START is ignored.
REQ-018 SHALL ignore FRM_START in ARMED and RUN.
REQ-019 SHALL move ARMED->RUN on the first VEC_LD.
REQ-020 SHALL, on every VEC_LD in ARMED or RUN, increment sym_cnt and advance the LFSR.
REQ-021 SHALL, when a VEC_LD makes sym_cnt equal the latched SYM_NUM, return to IDLE and pulse FRM_DONE in the following cycle.
REQ-022 SHALL ignore VEC_LD in IDLE.
REQ-023 SHALL use LFSR x^7+x^4+1: state s[6:0], polarity p = s[6]^s[3], next state {s[5:0], p}.
REQ-024 SHALL drive ALLOC_VEC, in ARMED and RUN, as the base map with every pilot code's high bit XORed with p (01<->11); 00 and 10 entries pass unchanged.
REQ-025 SHALL force ALLOC_VEC bits at and above 2*N to 0, where N is the carrier count for STD.
REQ-026 SHALL derive ALLOC_VEC from current state only, so it is valid in the same cycle VEC_LD is sampled; the next vector appears one cycle after VEC_LD.
REQ-027 SHALL drive ALLOC_VEC all zeros in IDLE or when STD = 11.
REQ-028 SHALL drive BUSY = 1 in ARMED and RUN, 0 in IDLE.

Reset
REQ-029 SHALL, on RST_I including mid-frame, enter IDLE with LFSR = SEED, sym_cnt = 0, latched SYM_NUM = 0, CFG_ACK_O = 0, FRM_DONE = 0, BUSY = 0 and ALLOC_VEC = 0.
REQ-030 SHALL clear the base map to zero on reset.

Verification
REQ-031 Write word 0 = 32'h0000_0061 in IDLE -> CFG_ACK_O high exactly one cycle later; after FRM_START with STD=00, ALLOC_VEC[7:0] = 8'h61.
REQ-032 Map carrier 1 = 01, SYM_NUM=8, STD=00, 8 VEC_LD pulses -> carrier-1 code sequence 01,01,01,01,11,11,11,01; FRM_DONE pulses once, the cycle after the 8th VEC_LD.
REQ-033 Write issued while BUSY -> no CFG_ACK_O and map unchanged until IDLE; the write then completes with ACK.
REQ-034 Map word 4 nonzero, STD=00 -> ALLOC_VEC[255:128] = 0; the same map with STD=01 -> word 4 visible.
REQ-035 RST_I asserted in RUN after 3 VEC_LD -> BUSY=0 and ALLOC_VEC=0 immediately; the next frame restarts polarity at p=0 (seed).
REQ-036 FRM_START with SYM_NUM=0 or STD=11 -> stays IDLE, BUSY=0, no FRM_DONE.
